iir_biquad_cascade: RTL and testbench

//  Parametrised successor to the single-section biquad: NUM_SECTIONS cascaded Direct Form

---
 rtl/iir_cascade_pkg.sv | 41 ++++
 rtl/iir_section_dp.sv | 72 +++++++
 rtl/iir_biquad_cascade.sv | 211 +++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cascade_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed biquad cascade.
// FSM states, coefficient ids, round-half-up shift and saturating reduction.
package iir_cascade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic [2:0] CID_B0 = 3'd0;
  localparam logic [2:0] CID_B1 = 3'd1;
  localparam logic [2:0] CID_B2 = 3'd2;
  localparam logic [2:0] CID_A1 = 3'd3;
  localparam logic [2:0] CID_A2 = 3'd4;

  // Round half up, then drop frac fraction bits.
  function automatic logic signed [63:0] rnd_shift(
    input logic signed [63:0] p,
    input int                 frac
  );
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (p + half) >>> frac;
  endfunction

  // Clamp v into the signed dw-bit range.
  function automatic logic signed [63:0] sat_reduce(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_section_dp.sv
// Combinational datapath of one transposed direct-form biquad section.
// Ports: x_i, b0_i..a2_i, d1_i, d2_i in; y_o, d1_o, d2_o, ovf_o out.
// IIR_CASCADE_SAT_EN selects clamping of y instead of wrap.
module iir_section_dp
  import iir_cascade_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 18,
  parameter int COEFF_FRAC  = 16,
  parameter int ACC_WIDTH   = 48
) (
  input  logic signed [DATA_WIDTH-1:0]  x_i,
  input  logic signed [COEFF_WIDTH-1:0] b0_i,
  input  logic signed [COEFF_WIDTH-1:0] b1_i,
  input  logic signed [COEFF_WIDTH-1:0] b2_i,
  input  logic signed [COEFF_WIDTH-1:0] a1_i,
  input  logic signed [COEFF_WIDTH-1:0] a2_i,
  input  logic signed [ACC_WIDTH-1:0]   d1_i,
  input  logic signed [ACC_WIDTH-1:0]   d2_i,
  output logic signed [DATA_WIDTH-1:0]  y_o,
  output logic signed [ACC_WIDTH-1:0]   d1_o,
  output logic signed [ACC_WIDTH-1:0]   d2_o,
  output logic                          ovf_o
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PW-1:0]         pb0;
  logic signed [PW-1:0]         pb1;
  logic signed [PW-1:0]         pb2;
  logic signed [PW-1:0]         pa1;
  logic signed [PW-1:0]         pa2;
  logic signed [ACC_WIDTH-1:0]  rb0;
  logic signed [ACC_WIDTH-1:0]  rb1;
  logic signed [ACC_WIDTH-1:0]  rb2;
  logic signed [ACC_WIDTH-1:0]  ra1;
  logic signed [ACC_WIDTH-1:0]  ra2;
  logic signed [ACC_WIDTH-1:0]  yfull;
  logic signed [DATA_WIDTH-1:0] y;

  assign pb0 = PW'(x_i) * PW'(b0_i);
  assign pb1 = PW'(x_i) * PW'(b1_i);
  assign pb2 = PW'(x_i) * PW'(b2_i);

  assign rb0 = ACC_WIDTH'(rnd_shift(64'(pb0), COEFF_FRAC));
  assign rb1 = ACC_WIDTH'(rnd_shift(64'(pb1), COEFF_FRAC));
  assign rb2 = ACC_WIDTH'(rnd_shift(64'(pb2), COEFF_FRAC));

  assign yfull = rb0 + d1_i;

  // In range iff all bits from the DW-1 sign bit upward agree.
  assign ovf_o = (|yfull[ACC_WIDTH-1:DATA_WIDTH-1])
               & ~(&yfull[ACC_WIDTH-1:DATA_WIDTH-1]);

`ifdef IIR_CASCADE_SAT_EN
  assign y = DATA_WIDTH'(sat_reduce(64'(yfull), DATA_WIDTH));
`else
  assign y = yfull[DATA_WIDTH-1:0];
`endif

  // Feedback uses the reduced y, as seen downstream.
  assign pa1 = PW'(y) * PW'(a1_i);
  assign pa2 = PW'(y) * PW'(a2_i);

  assign ra1 = ACC_WIDTH'(rnd_shift(64'(pa1), COEFF_FRAC));
  assign ra2 = ACC_WIDTH'(rnd_shift(64'(pa2), COEFF_FRAC));

  assign y_o  = y;
  assign d1_o = rb1 - ra1 + d2_i;
  assign d2_o = rb2 - ra2;

endmodule

// File: rtl/iir_biquad_cascade.sv
// NUM_SECTIONS cascaded biquads on one shared datapath, one section per clock.
// Ports: clk, rst; AXIS s_*/m_*; coeff_wr/sec/id/w, coeff_err; state_clr, ovf_sticky.
// IIR_CASCADE_SAT_EN: clamp out-of-range section outputs (default: wrap).
module iir_biquad_cascade
  import iir_cascade_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int COEFF_WIDTH  = 18,
  parameter int COEFF_FRAC   = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int NUM_SECTIONS = 4,
  localparam int SW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic signed [DATA_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic                          coeff_wr,
  input  logic [SW-1:0]                 coeff_sec,
  input  logic [2:0]                    coeff_id,
  input  logic signed [COEFF_WIDTH-1:0] coeff_w,
  output logic                          coeff_err,
  input  logic                          state_clr,
  output logic                          ovf_sticky
);

  localparam int N = NUM_SECTIONS;

  state_e                        state_q;
  logic [SW-1:0]                 sec_q;
  logic signed [DATA_WIDTH-1:0]  x_q;
  logic signed [DATA_WIDTH-1:0]  m_tdata_q;
  logic                          m_tvalid_q;
  logic                          coeff_err_q;
  logic                          ovf_q;

  logic signed [COEFF_WIDTH-1:0] b0_q [N];
  logic signed [COEFF_WIDTH-1:0] b1_q [N];
  logic signed [COEFF_WIDTH-1:0] b2_q [N];
  logic signed [COEFF_WIDTH-1:0] a1_q [N];
  logic signed [COEFF_WIDTH-1:0] a2_q [N];
  logic signed [ACC_WIDTH-1:0]   d1_q [N];
  logic signed [ACC_WIDTH-1:0]   d2_q [N];

  logic signed [COEFF_WIDTH-1:0] sel_b0;
  logic signed [COEFF_WIDTH-1:0] sel_b1;
  logic signed [COEFF_WIDTH-1:0] sel_b2;
  logic signed [COEFF_WIDTH-1:0] sel_a1;
  logic signed [COEFF_WIDTH-1:0] sel_a2;
  logic signed [ACC_WIDTH-1:0]   sel_d1;
  logic signed [ACC_WIDTH-1:0]   sel_d2;

  logic signed [DATA_WIDTH-1:0]  dp_y;
  logic signed [ACC_WIDTH-1:0]   dp_d1;
  logic signed [ACC_WIDTH-1:0]   dp_d2;
  logic                          dp_ovf;

  logic                          id_b0;
  logic                          id_b1;
  logic                          id_b2;
  logic                          id_a1;
  logic                          id_a2;
  logic                          id_ok;
  logic                          sec_ok;
  logic                          wr_ok;
  logic                          last_sec;

  assign s_tready   = (state_q == ST_IDLE);
  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign coeff_err  = coeff_err_q;
  assign ovf_sticky = ovf_q;

  assign id_b0  = (coeff_id == CID_B0);
  assign id_b1  = (coeff_id == CID_B1);
  assign id_b2  = (coeff_id == CID_B2);
  assign id_a1  = (coeff_id == CID_A1);
  assign id_a2  = (coeff_id == CID_A2);
  assign id_ok  = id_b0 | id_b1 | id_b2 | id_a1 | id_a2;
  // Widened so the compare stays meaningful when N is a power of two.
  assign sec_ok = (32'(coeff_sec) < 32'(N));
  assign wr_ok  = coeff_wr & (state_q == ST_IDLE) & id_ok & sec_ok;

  assign last_sec = (sec_q == SW'(N - 1));

  always_comb begin
    sel_b0 = '0;
    sel_b1 = '0;
    sel_b2 = '0;
    sel_a1 = '0;
    sel_a2 = '0;
    sel_d1 = '0;
    sel_d2 = '0;
    for (int i = 0; i < N; i++) begin
      if (sec_q == SW'(i)) begin
        sel_b0 = b0_q[i];
        sel_b1 = b1_q[i];
        sel_b2 = b2_q[i];
        sel_a1 = a1_q[i];
        sel_a2 = a2_q[i];
        sel_d1 = d1_q[i];
        sel_d2 = d2_q[i];
      end
    end
  end

  iir_section_dp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFF_FRAC  (COEFF_FRAC),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_dp (
    .x_i   (x_q),
    .b0_i  (sel_b0),
    .b1_i  (sel_b1),
    .b2_i  (sel_b2),
    .a1_i  (sel_a1),
    .a2_i  (sel_a2),
    .d1_i  (sel_d1),
    .d2_i  (sel_d2),
    .y_o   (dp_y),
    .d1_o  (dp_d1),
    .d2_o  (dp_d2),
    .ovf_o (dp_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      x_q         <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      coeff_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        b0_q[i] <= '0;
        b1_q[i] <= '0;
        b2_q[i] <= '0;
        a1_q[i] <= '0;
        a2_q[i] <= '0;
        d1_q[i] <= '0;
        d2_q[i] <= '0;
      end
    end else begin
      coeff_err_q <= coeff_wr & ~wr_ok;

      // Lands on the same edge a sample is accepted, so it is used by it.
      if (wr_ok) begin
        for (int i = 0; i < N; i++) begin
          if (coeff_sec == SW'(i)) begin
            unique case (1'b1)
              id_b0:   b0_q[i] <= coeff_w;
              id_b1:   b1_q[i] <= coeff_w;
              id_b2:   b2_q[i] <= coeff_w;
              id_a1:   a1_q[i] <= coeff_w;
              id_a2:   a2_q[i] <= coeff_w;
              default: ;
            endcase
          end
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (state_clr) begin
            ovf_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
              d1_q[i] <= '0;
              d2_q[i] <= '0;
            end
          end
          if (s_tvalid) begin
            x_q     <= s_tdata;
            sec_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < N; i++) begin
            if (sec_q == SW'(i)) begin
              d1_q[i] <= dp_d1;
              d2_q[i] <= dp_d2;
            end
          end
          if (dp_ovf) ovf_q <= 1'b1;
          x_q <= dp_y;
          if (last_sec) begin
            m_tdata_q  <= dp_y;
            m_tvalid_q <= 1'b1;
            state_q    <= ST_OUT;
          end else begin
            sec_q <= sec_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_tready) begin
            m_tvalid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench: a 2-section and a 1-section cascade driven side by side.
// Checks latency, impulse response, overflow, backpressure, coeff errors, reset.
module tb_iir_biquad_cascade;

  import iir_cascade_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [15:0] s_tdata;
  logic              vA;
  logic              vB;
  logic              m_tready;
  logic              wrA;
  logic              wrB;
  logic [0:0]        coeff_sec;
  logic [2:0]        coeff_id;
  logic signed [17:0] coeff_w;
  logic              state_clr;

  logic              rdyA;
  logic signed [15:0] mdA;
  logic              mvA;
  logic              errA;
  logic              ovfA;
  logic              rdyB;
  logic signed [15:0] mdB;
  logic              mvB;
  logic              errB;
  logic              ovfB;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iir_biquad_cascade #(.NUM_SECTIONS(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (vA),
    .s_tready   (rdyA),
    .m_tdata    (mdA),
    .m_tvalid   (mvA),
    .m_tready   (m_tready),
    .coeff_wr   (wrA),
    .coeff_sec  (coeff_sec),
    .coeff_id   (coeff_id),
    .coeff_w    (coeff_w),
    .coeff_err  (errA),
    .state_clr  (state_clr),
    .ovf_sticky (ovfA)
  );

  iir_biquad_cascade #(.NUM_SECTIONS(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (vB),
    .s_tready   (rdyB),
    .m_tdata    (mdB),
    .m_tvalid   (mvB),
    .m_tready   (m_tready),
    .coeff_wr   (wrB),
    .coeff_sec  (coeff_sec),
    .coeff_id   (coeff_id),
    .coeff_w    (coeff_w),
    .coeff_err  (errB),
    .state_clr  (state_clr),
    .ovf_sticky (ovfB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr_a(input logic sec, input logic [2:0] id,
                      input logic signed [17:0] w);
    coeff_sec = sec;
    coeff_id  = id;
    coeff_w   = w;
    wrA = 1'b1;
    tick();
    wrA = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] id, input logic signed [17:0] w);
    coeff_sec = 1'b0;
    coeff_id  = id;
    coeff_w   = w;
    wrB = 1'b1;
    tick();
    wrB = 1'b0;
  endtask

  // One-section unit: accept edge, one CALC edge, then OUT for one cycle.
  task automatic send_b(input string tag, input logic signed [15:0] x,
                        input logic signed [15:0] exp);
    s_tdata = x;
    vB = 1'b1;
    tick();
    vB = 1'b0;
    tick();
    chk({tag, "_v"}, 32'(mvB), 1);
    chk(tag, mdB, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0;
    vA = 1'b0;
    vB = 1'b0;
    m_tready = 1'b0;
    wrA = 1'b0;
    wrB = 1'b0;
    coeff_sec = '0;
    coeff_id = '0;
    coeff_w = '0;
    state_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_rdy", 32'(rdyA), 1);
    chk("rst_mv", 32'(mvA), 0);
    chk("rst_md", mdA, 0);
    chk("rst_err", 32'(errA), 0);
    chk("rst_ovf", 32'(ovfA), 0);

    // Two unity sections: 1000 passes through, valid 2 edges after accept.
    wr_a(1'b0, CID_B0, 18'sd65536);
    chk("wr_ok_err", 32'(errA), 0);
    wr_a(1'b1, CID_B0, 18'sd65536);
    s_tdata = 16'sd1000;
    vA = 1'b1;
    tick();
    s_tdata = 16'sd2000;
    chk("acc_rdy", 32'(rdyA), 0);
    chk("lat1_mv", 32'(mvA), 0);
    tick();
    chk("lat2_mv", 32'(mvA), 0);
    tick();
    chk("lat3_mv", 32'(mvA), 1);
    chk("pass_md", mdA, 1000);

    // Stall 5 cycles with a new sample already offered.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_md", mdA, 1000);
      chk("stall_mv", 32'(mvA), 1);
      chk("stall_rdy", 32'(rdyA), 0);
    end
    m_tready = 1'b1;
    tick();
    chk("rel_mv", 32'(mvA), 0);
    chk("rel_rdy", 32'(rdyA), 1);
    tick();
    vA = 1'b0;
    chk("next_rdy", 32'(rdyA), 0);
    tick();
    tick();
    chk("next_mv", 32'(mvA), 1);
    chk("next_md", mdA, 2000);
    tick();

    // One section, b0=1.0, a1=-0.5: impulse response halves each step.
    wr_b(CID_B0, 18'sd65536);
    wr_b(CID_A1, -18'sd32768);
    send_b("imp0", 16'sd16384, 16'sd16384);
    send_b("imp1", 16'sd0, 16'sd8192);
    send_b("imp2", 16'sd0, 16'sd4096);
    chk("imp_ovf", 32'(ovfB), 0);

    // b0 just under 2.0: 30000 -> round(59999.54)=60000, out of range.
    state_clr = 1'b1;
    tick();
    state_clr = 1'b0;
    wr_b(CID_A1, 18'sd0);
    wr_b(CID_B0, 18'sd131071);
`ifdef IIR_CASCADE_SAT_EN
    send_b("ovf_y", 16'sd30000, 16'sd32767);
`else
    send_b("ovf_y", 16'sd30000, -16'sd5536);
`endif
    chk("ovf_set", 32'(ovfB), 1);
    state_clr = 1'b1;
    tick();
    state_clr = 1'b0;
    chk("ovf_clr", 32'(ovfB), 0);

    // Write and accept on the same edge: sample sees b0=1.0.
    coeff_sec = 1'b0;
    coeff_id = CID_B0;
    coeff_w = 18'sd65536;
    wrB = 1'b1;
    s_tdata = 16'sd500;
    vB = 1'b1;
    tick();
    wrB = 1'b0;
    vB = 1'b0;
    tick();
    chk("wracc_md", mdB, 500);
    tick();

    // Write attempted while CALC: dropped and flagged.
    s_tdata = 16'sd1000;
    vA = 1'b1;
    tick();
    vA = 1'b0;
    coeff_sec = 1'b0;
    coeff_id = CID_B0;
    coeff_w = 18'sd0;
    wrA = 1'b1;
    tick();
    wrA = 1'b0;
    chk("calc_err", 32'(errA), 1);
    tick();
    chk("calc_err_end", 32'(errA), 0);
    chk("calc_md", mdA, 1000);
    tick();

    // Bad coefficient id in IDLE.
    wr_a(1'b0, 3'd6, 18'sd0);
    chk("id_err", 32'(errA), 1);
    tick();
    chk("id_err_end", 32'(errA), 0);
    s_tdata = -16'sd1234;
    vA = 1'b1;
    tick();
    vA = 1'b0;
    tick();
    tick();
    chk("id_md", mdA, -1234);
    tick();

    // Reset while CALC: sample dropped, coefficients back to zero.
    s_tdata = 16'sd1000;
    vA = 1'b1;
    tick();
    vA = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_mv", 32'(mvA), 0);
    chk("mrst_rdy", 32'(rdyA), 1);
    chk("mrst_md", mdA, 0);
    vA = 1'b1;
    tick();
    vA = 1'b0;
    tick();
    tick();
    chk("mrst_v", 32'(mvA), 1);
    chk("mrst_y", mdA, 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
